// File: rtl/diag_pkg.sv
// Shared opcodes, command-FSM states and default widths for the ROMulator
// diagnostics controller.
`timescale 1ns/1ps
package diag_pkg;

  localparam int unsigned VRAM_AW_DEF = 11;

  localparam logic [7:0] OP_HALT      = 8'h01;
  localparam logic [7:0] OP_RUN       = 8'h02;
  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_WRITE     = 8'h04;
  localparam logic [7:0] OP_VRAM_READ = 8'h05;
  localparam logic [7:0] OP_GET_CFG   = 8'h06;
  localparam logic [7:0] OP_SET_CFG   = 8'h07;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR_HI,
    ADDR_LO,
    STREAM_RD,
    STREAM_WR,
    VRAM_RD,
    SET_CFG
  } state_t;

endpackage

// File: rtl/spi_slave_byte.sv
// SPI mode-0 byte slave: input synchronizers, edge detect, RX/TX shifters,
// byte_valid pulse and load_tx strobe, all in the clk domain.
`timescale 1ns/1ps
module spi_slave_byte #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  input  logic [7:0] tx_byte,
  output logic       spi_miso,
  output logic       cs_active,
  output logic       cs_start,
  output logic       byte_valid,
  output logic       load_tx,
  output logic [7:0] rx_byte
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic       cs_prev_q, cs_prev_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       byte_valid_q, byte_valid_d;

  logic sclk_s, cs_n_s, mosi_s, sclk_rise, sclk_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_n_s    = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  assign cs_active  = ~cs_n_s;
  assign cs_start   = cs_prev_q & ~cs_n_s;
  assign spi_miso   = tx_q[7];
  assign byte_valid = byte_valid_q;
  assign rx_byte    = rx_byte_q;

  always_comb begin
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
    cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_prev_d  = sclk_s;
    cs_prev_d    = cs_n_s;
    bit_cnt_d    = bit_cnt_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    load_tx      = 1'b0;
    if (cs_n_s) begin
      bit_cnt_d = '0;
      rx_d      = '0;
      tx_d      = '0;
    end else if (cs_start) begin
      bit_cnt_d = '0;
      rx_d      = '0;
      tx_d      = tx_byte;
      load_tx   = 1'b1;
    end else begin
      if (sclk_rise) begin
        rx_d      = {rx_q[5:0], mosi_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_valid_d = 1'b1;
          rx_byte_d    = {rx_q, mosi_s};
        end
      end
      // The falling edge that closes a byte slot presents the next byte's MSB.
      if (sclk_fall) begin
        if (bit_cnt_q == 3'd0) begin
          tx_d    = tx_byte;
          load_tx = 1'b1;
        end else begin
          tx_d = {tx_q[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q  <= '0;
      cs_sync_q    <= '1;
      mosi_sync_q  <= '0;
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b1;
      bit_cnt_q    <= '0;
      rx_q         <= '0;
      tx_q         <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      cs_sync_q    <= cs_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      cs_prev_q    <= cs_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
    end
  end

endmodule

// File: rtl/cpu_diagnostics.sv
// ROMulator SPI diagnostics controller: CPU halt, RAM peek/poke, config access.
// Define DIAG_VRAM_EN to enable the video-RAM streaming opcode 0x05.
`timescale 1ns/1ps
module cpu_diagnostics
  import diag_pkg::*;
#(
  parameter int unsigned CLK_SYNC_STAGES = 2,
  parameter int unsigned VRAM_AW         = VRAM_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_cs_n,
  input  logic               spi_clk,
  input  logic               spi_mosi,
  output logic               spi_miso,
  output logic               halt,
  output logic [15:0]        ram_addr,
  input  logic [7:0]         ram_rdata,
  output logic [7:0]         ram_wdata,
  output logic               ram_we,
  output logic               ram_cs,
  input  logic [3:0]         configuration,
  input  logic [3:0]         flash_addr,
  output logic [VRAM_AW-1:0] vram_raddr,
  input  logic [7:0]         vram_rdata,
  output logic               vram_rclk,
  input  logic [VRAM_AW-1:0] vram_size,
  output logic [3:0]         config_byte
);

  logic       cs_active, cs_start, byte_valid, load_tx;
  logic [7:0] rx_byte;

  state_t      state_q, state_d;
  logic        halt_q, halt_d;
  logic [15:0] addr_q, addr_d;
  logic        is_wr_q, is_wr_d;
  logic [7:0]  resp_q, resp_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_wdata_q, ram_wdata_d;
  logic        ram_we_q, ram_we_d;
  logic        ram_cs_q, ram_cs_d;
  logic        cap_q, cap_d;
  logic [3:0]  config_q, config_d;

  spi_slave_byte #(
    .SYNC_STAGES(CLK_SYNC_STAGES)
  ) u_spi (
    .clk       (clk),
    .rst       (rst),
    .spi_clk   (spi_clk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .tx_byte   (resp_q),
    .spi_miso  (spi_miso),
    .cs_active (cs_active),
    .cs_start  (cs_start),
    .byte_valid(byte_valid),
    .load_tx   (load_tx),
    .rx_byte   (rx_byte)
  );

`ifdef DIAG_VRAM_EN
  logic [VRAM_AW-1:0] vram_raddr_q, vram_raddr_d, vram_next;
  logic               vrd_q, vrd_d, vcap_q, vcap_d;

  assign vram_raddr = vram_raddr_q;
  assign vram_rclk  = clk;

  always_comb begin
    vram_next = vram_raddr_q + VRAM_AW'(1);
    if (vram_size == '0 || vram_raddr_q == vram_size - VRAM_AW'(1)) begin
      vram_next = '0;
    end
  end
`else
  logic unused_vram;
  assign unused_vram = ^{vram_rdata, vram_size};
  assign vram_raddr  = '0;
  assign vram_rclk   = 1'b0;
`endif

  assign halt        = halt_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_we      = ram_we_q;
  assign ram_cs      = ram_cs_q;
  assign config_byte = config_q;

  always_comb begin
    state_d     = state_q;
    halt_d      = halt_q;
    addr_d      = addr_q;
    is_wr_d     = is_wr_q;
    resp_d      = resp_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    ram_cs_d    = 1'b0;
    config_d    = config_q;
    cap_d       = ram_cs_q & ~ram_we_q;
`ifdef DIAG_VRAM_EN
    vram_raddr_d = vram_raddr_q;
    vrd_d        = 1'b0;
    vcap_d       = vrd_q;
`endif

    // Single-shot responses are cleared once the shifter has taken them.
    if (load_tx && !(state_q inside {STREAM_RD, VRAM_RD})) resp_d = '0;
    if (cap_q && state_q == STREAM_RD) resp_d = ram_rdata;
`ifdef DIAG_VRAM_EN
    if (vcap_q && state_q == VRAM_RD) resp_d = vram_rdata;
`endif

    if (!cs_active) begin
      state_d = IDLE;
      resp_d  = '0;
    end else if (cs_start) begin
      state_d = CMD;
    end else if (byte_valid) begin
      case (state_q)
        CMD: begin
          state_d = IDLE;
          case (rx_byte)
            OP_HALT: halt_d = 1'b1;
            OP_RUN:  halt_d = 1'b0;
            OP_READ, OP_WRITE: begin
              if (halt_q) begin
                is_wr_d = (rx_byte == OP_WRITE);
                state_d = ADDR_HI;
              end
            end
            OP_GET_CFG: resp_d  = {flash_addr, configuration};
            OP_SET_CFG: state_d = SET_CFG;
`ifdef DIAG_VRAM_EN
            OP_VRAM_READ: begin
              vram_raddr_d = '0;
              vrd_d        = 1'b1;
              state_d      = VRAM_RD;
            end
`endif
            default: state_d = IDLE;
          endcase
        end
        ADDR_HI: begin
          addr_d  = {rx_byte, addr_q[7:0]};
          state_d = ADDR_LO;
        end
        ADDR_LO: begin
          if (is_wr_q) begin
            addr_d  = {addr_q[15:8], rx_byte};
            state_d = STREAM_WR;
          end else begin
            // Fetch one byte ahead so data is ready for the next slot.
            ram_addr_d = {addr_q[15:8], rx_byte};
            ram_cs_d   = 1'b1;
            addr_d     = {addr_q[15:8], rx_byte} + 16'd1;
            state_d    = STREAM_RD;
          end
        end
        STREAM_RD: begin
          ram_addr_d = addr_q;
          ram_cs_d   = 1'b1;
          addr_d     = addr_q + 16'd1;
        end
        STREAM_WR: begin
          ram_addr_d  = addr_q;
          ram_wdata_d = rx_byte;
          ram_cs_d    = 1'b1;
          ram_we_d    = 1'b1;
          addr_d      = addr_q + 16'd1;
        end
        SET_CFG: begin
          config_d = rx_byte[3:0];
          state_d  = IDLE;
        end
`ifdef DIAG_VRAM_EN
        VRAM_RD: begin
          vram_raddr_d = vram_next;
          vrd_d        = 1'b1;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      halt_q       <= 1'b0;
      addr_q       <= '0;
      is_wr_q      <= 1'b0;
      resp_q       <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_we_q     <= 1'b0;
      ram_cs_q     <= 1'b0;
      cap_q        <= 1'b0;
      config_q     <= '0;
`ifdef DIAG_VRAM_EN
      vram_raddr_q <= '0;
      vrd_q        <= 1'b0;
      vcap_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      halt_q       <= halt_d;
      addr_q       <= addr_d;
      is_wr_q      <= is_wr_d;
      resp_q       <= resp_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_we_q     <= ram_we_d;
      ram_cs_q     <= ram_cs_d;
      cap_q        <= cap_d;
      config_q     <= config_d;
`ifdef DIAG_VRAM_EN
      vram_raddr_q <= vram_raddr_d;
      vrd_q        <= vrd_d;
      vcap_q       <= vcap_d;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_diagnostics.sv
// Scoreboard bench for cpu_diagnostics: expected MISO bytes and RAM accesses
// are queued at stimulus time and checked by independent monitors.
`timescale 1ns/1ps
module tb_cpu_diagnostics;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_cs_n, spi_clk, spi_mosi;
  logic        spi_miso, halt;
  logic [15:0] ram_addr;
  logic [7:0]  ram_rdata = 8'h00;
  logic [7:0]  ram_wdata;
  logic        ram_we, ram_cs;
  logic [3:0]  configuration, flash_addr;
  logic [10:0] vram_raddr;
  logic [7:0]  vram_rdata = 8'h00;
  logic        vram_rclk;
  logic [10:0] vram_size;
  logic [3:0]  config_byte;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [7:0]  data;
  } ram_ev_t;

  ram_ev_t    exp_ram[$];
  logic [7:0] exp_miso[$];
  logic [7:0] txq[$];

  logic [7:0] mem  [0:65535];
  logic [7:0] vmem [0:2047];

  always #5 clk = ~clk;

  cpu_diagnostics #(
    .CLK_SYNC_STAGES(2),
    .VRAM_AW(11)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .spi_cs_n     (spi_cs_n),
    .spi_clk      (spi_clk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .halt         (halt),
    .ram_addr     (ram_addr),
    .ram_rdata    (ram_rdata),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .ram_cs       (ram_cs),
    .configuration(configuration),
    .flash_addr   (flash_addr),
    .vram_raddr   (vram_raddr),
    .vram_rdata   (vram_rdata),
    .vram_rclk    (vram_rclk),
    .vram_size    (vram_size),
    .config_byte  (config_byte)
  );

  // Synchronous RAM / VRAM models with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
    vram_rdata <= vmem[vram_raddr];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // RAM bus monitor: every strobe must match the next queued access.
  ram_ev_t ev;
  always @(negedge clk) begin
    if (!rst && ram_cs) begin
      if (exp_ram.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ram_unexpected: got we=%0b addr=0x%0h data=0x%0h, expected no access",
                 ram_we, ram_addr, ram_wdata);
      end else begin
        ev = exp_ram.pop_front();
        check("ram_we", int'(ram_we), int'(ev.we));
        check("ram_addr", int'(ram_addr), int'(ev.addr));
        if (ev.we) check("ram_wdata", int'(ram_wdata), int'(ev.data));
        check("ram_cs_while_cs_n_high", int'(spi_cs_n), 0);
      end
    end
  end

  // MISO monitor: master-side sampling on spi_clk rising, one compare per byte.
  logic [7:0] mon_sh;
  int         mon_bits = 0;
  logic [7:0] mon_exp;
  always @(posedge spi_clk or posedge spi_cs_n) begin
    if (spi_cs_n) begin
      mon_bits = 0;
    end else begin
      mon_sh = {mon_sh[6:0], spi_miso};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        if (exp_miso.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL miso_unexpected: got 0x%0h, expected no byte", mon_sh);
        end else begin
          mon_exp = exp_miso.pop_front();
          check("miso_byte", int'(mon_sh), int'(mon_exp));
        end
      end
    end
  end

  task automatic put(input logic [7:0] t, input logic [7:0] e);
    txq.push_back(t);
    exp_miso.push_back(e);
  endtask

  task automatic exp_rd(input logic [15:0] a);
    ram_ev_t r;
    r.we = 1'b0; r.addr = a; r.data = 8'h00;
    exp_ram.push_back(r);
  endtask

  task automatic exp_wr(input logic [15:0] a, input logic [7:0] d);
    ram_ev_t r;
    r.we = 1'b1; r.addr = a; r.data = d;
    exp_ram.push_back(r);
  endtask

  task automatic cs_lo();
    spi_cs_n = 1'b0;
    #100;
  endtask

  task automatic cs_hi();
    #100 spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    #300;
  endtask

  task automatic shift_bits(input logic [7:0] b, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      spi_mosi = b[3'(7 - i)];
      #80 spi_clk = 1'b1;
      #80 spi_clk = 1'b0;
    end
  endtask

  task automatic txn();
    cs_lo();
    while (txq.size() > 0) shift_bits(txq.pop_front(), 8);
    cs_hi();
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    configuration = 4'h5; flash_addr = 4'h3; vram_size = 11'd3;
    for (int i = 0; i < 2048; i++) vmem[i] = 8'hEE;
    vmem[0] = 8'h10; vmem[1] = 8'h21; vmem[2] = 8'h32;
    mem[16'h1236] = 8'h77; mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'hC3;
    mem[16'h0001] = 8'h99; mem[16'h0020] = 8'h11; mem[16'h0021] = 8'h22;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    check("reset_halt", int'(halt), 0);
    check("reset_ram_cs", int'(ram_cs), 0);
    check("reset_ram_we", int'(ram_we), 0);
    check("reset_ram_addr", int'(ram_addr), 0);
    check("reset_ram_wdata", int'(ram_wdata), 0);
    check("reset_config_byte", int'(config_byte), 0);
    check("reset_miso", int'(spi_miso), 0);
    check("reset_vram_raddr", int'(vram_raddr), 0);

    put(8'h01, 8'h00); txn();
    check("halt_after_0x01", int'(halt), 1);
    put(8'h02, 8'h00); txn();
    check("halt_after_0x02", int'(halt), 0);
    put(8'h01, 8'h00); txn();
    check("halt_again", int'(halt), 1);

    put(8'h04, 8'h00); put(8'h12, 8'h00); put(8'h34, 8'h00);
    put(8'hAA, 8'h00); put(8'hBB, 8'h00);
    exp_wr(16'h1234, 8'hAA); exp_wr(16'h1235, 8'hBB);
    txn();

    // The read stream prefetches one address past the last byte clocked.
    put(8'h03, 8'h00); put(8'h12, 8'h00); put(8'h34, 8'h00);
    put(8'h00, 8'hAA); put(8'h00, 8'hBB);
    exp_rd(16'h1234); exp_rd(16'h1235); exp_rd(16'h1236);
    txn();

    put(8'h03, 8'h00); put(8'hFF, 8'h00); put(8'hFF, 8'h00);
    put(8'h00, 8'h5A); put(8'h00, 8'hC3);
    exp_rd(16'hFFFF); exp_rd(16'h0000); exp_rd(16'h0001);
    txn();

    put(8'h02, 8'h00); txn();
    check("halt_released", int'(halt), 0);
    put(8'h04, 8'h00); put(8'h00, 8'h00); put(8'h10, 8'h00); put(8'h55, 8'h00);
    txn();
    put(8'h03, 8'h00); put(8'h00, 8'h00); put(8'h20, 8'h00); put(8'h00, 8'h00);
    txn();

    put(8'h01, 8'h00); txn();
    exp_miso.push_back(8'h00); exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
    cs_lo();
    shift_bits(8'h04, 8); shift_bits(8'h00, 8); shift_bits(8'h20, 8);
    shift_bits(8'hF0, 4);
    cs_hi();
    put(8'h03, 8'h00); put(8'h00, 8'h00); put(8'h20, 8'h00); put(8'h00, 8'h11);
    exp_rd(16'h0020); exp_rd(16'h0021);
    txn();

    put(8'h06, 8'h00); put(8'h00, 8'h35); put(8'h00, 8'h00); txn();
    put(8'h07, 8'h00); put(8'h0C, 8'h00); txn();
    check("config_byte_set", int'(config_byte), 12);
    put(8'h09, 8'h00); put(8'h03, 8'h00); put(8'h12, 8'h00); txn();

`ifdef DIAG_VRAM_EN
    put(8'h05, 8'h00); put(8'h00, 8'h10); put(8'h00, 8'h21);
    put(8'h00, 8'h32); put(8'h00, 8'h10);
    txn();
    vram_size = 11'd0;
    put(8'h05, 8'h00); put(8'h00, 8'h10); put(8'h00, 8'h10);
    txn();
`else
    put(8'h05, 8'h00); put(8'h00, 8'h00); put(8'h00, 8'h00);
    txn();
    check("vram_raddr_tied", int'(vram_raddr), 0);
    check("vram_rclk_tied", int'(vram_rclk), 0);
`endif

    check("halt_before_abort", int'(halt), 1);
    exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
    cs_lo();
    shift_bits(8'h04, 8); shift_bits(8'h12, 8);
    #100 rst = 1'b1;
    #50;
    check("halt_after_reset_abort", int'(halt), 0);
    check("config_after_reset", int'(config_byte), 0);
    spi_cs_n = 1'b1;
    #50 rst = 1'b0;
    #300;

    #1000;
    check("miso_queue_drained", exp_miso.size(), 0);
    check("ram_queue_drained", exp_ram.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_diagnostics.md
Name: cpu_diagnostics

Overview:
SPI-slave diagnostics controller for the ROMulator. It halts the host 8-bit CPU and, while the CPU is halted, gives an external SPI master read/write access to the 64 KB emulation RAM. It also streams the video-RAM window and reports or sets the configuration. It runs on the 48 MHz internal oscillator clock and takes over the RAM port whenever `halt`=1.

Parameters:
CLK_SYNC_STAGES, 2, synchronizer depth for spi_clk, spi_cs_n, spi_mosi
VRAM_AW, 11, video-RAM address width

Ports:
clk  in  1  system clock (48 MHz HFOSC)
rst  in  1  asynchronous, active-high reset
spi_cs_n  in  1  SPI chip select, active low
spi_clk  in  1  SPI clock, mode 0
spi_mosi  in  1  SPI data from master
spi_miso  out  1  SPI data to master
halt  out  1  1 = CPU held (RDY low), RAM port owned by this block
ram_addr  out  16  RAM address
ram_rdata  in  8  RAM read data, 1-cycle synchronous latency
ram_wdata  out  8  RAM write data
ram_we  out  1  RAM write enable
ram_cs  out  1  RAM access strobe
configuration  in  4  active ROM configuration
flash_addr  in  4  selected flash image index
vram_raddr  out  11  video-RAM read address
vram_rdata  in  8  video-RAM data, 1-cycle latency
vram_rclk  out  1  video-RAM read clock, equal to clk
vram_size  in  11  number of valid video-RAM bytes
config_byte  out  4  configuration requested by the master

Behaviour:
- Reset values: `halt`=0, `ram_*`=0, `vram_raddr`=0, `config_byte`=0, `spi_miso`=0, state IDLE.
- SPI inputs are synchronized with CLK_SYNC_STAGES flip-flops, and edges are detected in the clk domain.
  - spi_clk must be ≤ clk/8.
  - On a rising edge, sample MOSI, MSB first.
  - On a falling edge, shift MISO.
  - Each response byte is loaded so its MSB is on MISO before the first rising edge of its byte slot.
- `spi_cs_n` high: return to IDLE, discard any partial byte, drive MISO 0. No write occurs for an incomplete byte.
- The first byte of each transaction is the opcode. States: IDLE, CMD, ADDR_HI, ADDR_LO, STREAM_RD, STREAM_WR, VRAM_RD, SET_CFG.
  - 0x01 HALT: `halt`<=1.
  - 0x02 RUN: `halt`<=0.
  - 0x03 READ: address high byte, address low byte, then data.
    - On receiving the low byte, issue `ram_cs`=1 for one clk at that address.
    - Capture `ram_rdata` on the next clk and load it into the shift register.
    - Each following byte slot returns RAM[addr], and addr increments by one per byte.
  - 0x04 WRITE: address high byte, address low byte, then data bytes.
    - On each complete data byte, pulse `ram_cs`=`ram_we`=1 for one clk with `ram_wdata`=byte.
    - The address then increments.
  - 0x06 GET_CONFIG: the next byte slot returns {flash_addr, configuration}.
  - 0x07 SET_CONFIG: the low nibble of the next byte goes to `config_byte`.
  - Unknown opcode: ignore the rest of the transaction, MISO 0.
- READ and WRITE while `halt`=0 are ignored.
  - Read bytes return 0x00.
  - `ram_cs` stays 0.
- Address arithmetic is 16-bit and wraps 0xFFFF→0x0000.
- `ram_cs`/`ram_we` are single-cycle pulses; they are never asserted while `spi_cs_n` is high.
- Response bytes before the first data slot are 0x00.
- Reset during a transaction aborts it and releases `halt`.

Optional Feature:
DIAG_VRAM_EN
- Defined: opcode 0x05 VRAM_READ streams video RAM.
  - Streaming starts at index 0 and increments per byte.
  - The index wraps to 0 after vram_size−1.
  - If vram_size=0, the index is held at 0.
- Undefined: opcode 0x05 is treated as unknown, `vram_raddr` is tied to 0, `vram_rclk` is tied to 0.

Decomposition:
- Package diag_pkg holds the opcode constants, state enum, and the VRAM_AW default.
- Sub-module spi_slave_byte contains the synchronizers, edge detect, 8-bit RX/TX shifters, byte_valid pulse and load_tx strobe.
- The command FSM stays in cpu_diagnostics.

Test Plan:
1. Reset, then transaction 0x01 → `halt`=1; transaction 0x02 → `halt`=0.
2. Halted: 0x04,0x12,0x34,0xAA,0xBB → `ram_we` pulses at 0x1234=AA and 0x1235=BB, one clk each.
3. Halted, RAM preloaded: 0x03,0x12,0x34 followed by 2 dummy bytes → MISO returns 0xAA then 0xBB.
4. Halted: read starting at 0xFFFF for 2 bytes → addresses 0xFFFF then 0x0000.
5. Not halted: 0x04,0x00,0x10,0x55 → no `ram_cs`; `spi_cs_n` raised after 4 bits of a write data byte → no write.
6. configuration=0x5, flash_addr=0x3: 0x06 → 0x35; 0x07,0x0C → `config_byte`=0xC. With DIAG_VRAM_EN and vram_size=3, 0x05 plus 4 bytes → vram indices 0,1,2,0.
